// File: rtl/obstacle_alert_pkg.sv
// Shared types and helpers for the obstacle alert chain: FSM states, channel
// encoding and the lowest-index-wins priority decode used upstream as well.
package obstacle_alert_pkg;

    typedef enum logic [1:0] {
        ALERT_IDLE = 2'd0,
        ALERT_ON   = 2'd1,
        ALERT_OFF  = 2'd2
    } alert_state_t;

    typedef logic [1:0] alert_ch_t;

    localparam alert_ch_t CH_NONE   = 2'd0;
    localparam alert_ch_t CH_LEFT   = 2'd1;
    localparam alert_ch_t CH_CENTRE = 2'd2;
    localparam alert_ch_t CH_RIGHT  = 2'd3;

    // bit0 (left) beats bit1 (centre) beats bit2 (right)
    function automatic alert_ch_t prio_decode(input logic [2:0] w);
        alert_ch_t ch;
        if (w[0])
            ch = CH_LEFT;
        else if (w[1])
            ch = CH_CENTRE;
        else if (w[2])
            ch = CH_RIGHT;
        else
            ch = CH_NONE;
        return ch;
    endfunction

endpackage

// File: rtl/alert_tick_gen.sv
// Free-running prescaler producing a single-cycle tick every PRESCALE clocks,
// with a synchronous clear so a new beep pattern starts on a fresh tick period.
module alert_tick_gen #(
    parameter int PRESCALE = 1000,
    parameter int CW       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    logic [CW-1:0] pre_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            pre_cnt_reg <= '0;
        else if (pre_cnt_reg == CW'(PRESCALE - 1))
            pre_cnt_reg <= '0;
        else
            pre_cnt_reg <= pre_cnt_reg + CW'(1);
    end

    assign tick = (pre_cnt_reg == CW'(PRESCALE - 1));

endmodule

// File: rtl/obstacle_alert_driver.sv
// Turns level warnings into pulsed one-hot actuator drive with a beep pattern,
// priority selection between directions and a minimum hold after the warning drops.
module obstacle_alert_driver
    import obstacle_alert_pkg::*;
#(
    parameter int PRESCALE   = 1000,
    parameter int ON_TICKS   = 4,
    parameter int OFF_TICKS  = 4,
    parameter int HOLD_TICKS = 16,
    parameter int CW         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] warning_in,
    output logic [2:0] alert_out,
    output logic       active,
    output logic       holding
);

    alert_state_t  state_reg, state_next;
    alert_ch_t     sel_reg, sel_next;
    logic [CW-1:0] phase_reg, phase_next;
    logic [CW-1:0] hold_reg, hold_next;
    logic [2:0]    w_q_reg;
    alert_ch_t     req_ch;
    logic          tick;
    logic          restart;
    logic          advance;

    assign req_ch = prio_decode(w_q_reg);

    alert_tick_gen #(
        .PRESCALE (PRESCALE),
        .CW       (CW)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart || !ena),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            state_reg <= ALERT_IDLE;
            sel_reg   <= CH_NONE;
            phase_reg <= '0;
            hold_reg  <= '0;
            w_q_reg   <= 3'b000;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            phase_reg <= phase_next;
            hold_reg  <= hold_next;
            w_q_reg   <= warning_in;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        phase_next = phase_reg;
        hold_next  = hold_reg;
        restart    = 1'b0;
        advance    = 1'b0;

        case (state_reg)
            ALERT_IDLE: begin
                if (req_ch != CH_NONE)
                    restart = 1'b1;
            end
            default: begin
                if (req_ch != CH_NONE && req_ch != sel_reg) begin
                    restart = 1'b1;
                end else if (req_ch == sel_reg) begin
                    hold_next = CW'(HOLD_TICKS);
                    advance   = 1'b1;
                end else if (hold_reg == '0) begin
                    // hold exhausted: drop out immediately, mid-beep or not
                    state_next = ALERT_IDLE;
                    sel_next   = CH_NONE;
                    phase_next = '0;
                end else begin
                    if (tick)
                        hold_next = hold_reg - CW'(1);
                    advance = 1'b1;
                end
            end
        endcase

        if (advance && tick) begin
            if (phase_reg <= CW'(1)) begin
                if (state_reg == ALERT_ON) begin
                    state_next = ALERT_OFF;
                    phase_next = CW'(OFF_TICKS);
                end else begin
                    state_next = ALERT_ON;
                    phase_next = CW'(ON_TICKS);
                end
            end else begin
                phase_next = phase_reg - CW'(1);
            end
        end

        // a new or higher-priority channel always starts a fresh ON phase
        if (restart) begin
            state_next = ALERT_ON;
            sel_next   = req_ch;
            phase_next = CW'(ON_TICKS);
            hold_next  = CW'(HOLD_TICKS);
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_alert
            assign alert_out[gi] = ena && (state_reg == ALERT_ON) && (sel_reg == 2'(gi + 1));
        end
    endgenerate

    assign active  = ena && (state_reg != ALERT_IDLE);
    assign holding = ena && (state_reg != ALERT_IDLE) && (w_q_reg == 3'b000) && (hold_reg != '0);

endmodule

// File: tb/tb_obstacle_alert_driver.sv
// Randomised and directed stimulus checked every cycle against a timing model
// that derives beeps and ticks from elapsed cycles since the last pattern start.
module tb_obstacle_alert_driver;

    localparam int P  = 4;
    localparam int ON = 2;
    localparam int OF = 2;
    localparam int H  = 5;
    localparam int CW = 16;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] warning_in;
    logic [2:0] alert_out;
    logic       active;
    logic       holding;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         e = 0;
    bit         m_act = 0;
    int         m_sel = 0;
    int         m_start = 0;
    int         m_hold = 0;
    logic [2:0] m_wq = 3'b000;

    obstacle_alert_driver #(
        .PRESCALE   (P),
        .ON_TICKS   (ON),
        .OFF_TICKS  (OF),
        .HOLD_TICKS (H),
        .CW         (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .warning_in (warning_in),
        .alert_out  (alert_out),
        .active     (active),
        .holding    (holding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s edge %0d got %0h expected %0h", tag, e, obs, exp_v);
        end
    endtask

    function automatic int prio(input logic [2:0] w);
        for (int i = 0; i < 3; i++)
            if (w[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_edge();
        int req;
        bit tk;
        e++;
        if (!rst_n || !ena) begin
            m_act  = 0;
            m_sel  = 0;
            m_hold = 0;
            m_wq   = 3'b000;
        end else begin
            req = prio(m_wq);
            tk  = m_act && (((e - 1 - m_start) % P) == P - 1);
            if ((!m_act && req != 0) || (m_act && req != 0 && req != m_sel)) begin
                m_act   = 1;
                m_sel   = req;
                m_start = e;
                m_hold  = H;
            end else if (m_act && req == m_sel) begin
                m_hold = H;
            end else if (m_act && m_hold == 0) begin
                m_act = 0;
                m_sel = 0;
            end else if (m_act && tk) begin
                m_hold--;
            end
            m_wq = warning_in;
        end
    endtask

    task automatic compare(input string tag);
        logic [2:0] one;
        logic [2:0] exp_alert;
        bit         beep_on;
        one       = 3'b001;
        beep_on   = m_act && ((((e - m_start) / P) % (ON + OF)) < ON);
        exp_alert = (ena && beep_on) ? (one << (m_sel - 1)) : 3'b000;
        check_val({tag, ".alert"}, 8'(alert_out), 8'(exp_alert));
        check_val({tag, ".active"}, 8'(active), 8'(ena && m_act));
        check_val({tag, ".holding"}, 8'(holding), 8'(ena && m_act && m_wq == 3'b000 && m_hold != 0));
    endtask

    task automatic run(input string tag, input int n);
        $display("TXN %-12s rst_n=%b ena=%b warning_in=%b cycles=%0d", tag, rst_n, ena, warning_in, n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare(tag);
        end
    endtask

    initial begin
        int         r;
        logic [2:0] w;

        rst_n      = 1'b0;
        ena        = 1'b1;
        warning_in = 3'b111;
        run("reset", 3);
        rst_n      = 1'b1;
        warning_in = 3'b000;
        run("idle", 6);

        warning_in = 3'b001;
        run("steady", 40);
        warning_in = 3'b000;
        run("release", 30);

        warning_in = 3'b001;
        run("short_warn", 3);
        warning_in = 3'b000;
        run("hold_expiry", 30);

        warning_in = 3'b001;
        run("to_off", 12);
        warning_in = 3'b100;
        run("switch", 20);

        warning_in = 3'b110;
        run("prio_110", 20);
        warning_in = 3'b101;
        run("prio_101", 20);

        warning_in = 3'b000;
        run("drain", 30);
        warning_in = 3'b001;
        run("on_again", 4);
        ena = 1'b0;
        run("ena_drop", 1);
        ena = 1'b1;
        run("ena_back", 20);

        warning_in = 3'b000;
        run("hold_mid", 6);
        warning_in = 3'b001;
        run("reassert", 20);

        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 11));
            if (r < 3)
                w = 3'b000;
            else
                w = 3'($urandom_range(1, 7));
            warning_in = w;
            if (r == 10) begin
                ena = 1'b0;
                run("rand_ena", 1);
                ena = 1'b1;
            end else if (r == 11) begin
                rst_n = 1'b0;
                run("rand_rst", 1);
                rst_n = 1'b1;
            end
            run("rand", int'($urandom_range(1, 25)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
